// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Holds the arbiter state encoding and the source-index width function.
package stream_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit index field.
  function automatic int unsigned id_width(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Requester-side and downstream-side valid/ready signals of the stream arbiter.
// The arbiter takes the slave modport; the environment driving it takes master.
interface stream_rr_arbiter_if #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned ID_WIDTH = stream_rr_arbiter_pkg::id_width(NUM_IN);

  logic [NUM_IN*DATA_WIDTH-1:0] data_in;
  logic [NUM_IN-1:0]            data_in_last;
  logic [NUM_IN-1:0]            data_in_valid;
  logic [NUM_IN-1:0]            data_in_ready;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         data_out_last;
  logic [ID_WIDTH-1:0]          data_out_id;
  logic                         data_out_valid;
  logic                         data_out_ready;

  modport slave (
    input  data_in,
    input  data_in_last,
    input  data_in_valid,
    output data_in_ready,
    output data_out,
    output data_out_last,
    output data_out_id,
    output data_out_valid,
    input  data_out_ready
  );

  modport master (
    output data_in,
    output data_in_last,
    output data_in_valid,
    input  data_in_ready,
    input  data_out,
    input  data_out_last,
    input  data_out_id,
    input  data_out_valid,
    output data_out_ready
  );

endinterface

// File: rtl/stream_rr_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request strictly after the pointer, with wrap.
// The request vector is doubled and rotated so a plain find-first does the search.
module rr_priority_picker #(
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_IN-1:0]   i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [ID_WIDTH-1:0] o_grant,
  output logic                o_grant_valid
);

  logic [2*NUM_IN-1:0] w_dbl;
  logic [NUM_IN-1:0]   w_rot;
  int unsigned         w_start;
  int unsigned         w_sum;

  always_comb begin
    w_dbl         = {i_req, i_req};
    w_start       = 32'(i_ptr) + 32'd1;
    w_rot         = NUM_IN'(w_dbl >> w_start);
    w_sum         = 0;
    o_grant       = '0;
    o_grant_valid = 1'b0;
    // Descending scan so the lowest rotated position is the one that sticks.
    for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = w_start + unsigned'(k);
        if (w_sum >= NUM_IN) begin
          w_sum = w_sum - NUM_IN;
        end
        o_grant       = ID_WIDTH'(w_sum);
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output slot among NUM_IN streams,
// optionally holding the grant for a whole packet until the beat carrying last.
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IN       = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter bit          LOCK_ON_LAST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  stream_rr_arbiter_if.slave  arb
);

  localparam int unsigned ID_WIDTH = id_width(NUM_IN);

  arb_state_e            r_state;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   r_lock_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_valid;

  logic                  w_slot_free;
  logic [ID_WIDTH-1:0]   w_rr_grant;
  logic                  w_rr_valid;
  logic [ID_WIDTH-1:0]   w_grant;
  logic                  w_grant_valid;
  logic [NUM_IN-1:0]     w_ready;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;
  logic                  w_xfer;
  logic                  w_end;

  rr_priority_picker #(
    .NUM_IN   (NUM_IN),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .i_req         (arb.data_in_valid),
    .i_ptr         (r_ptr),
    .o_grant       (w_rr_grant),
    .o_grant_valid (w_rr_valid)
  );

  assign w_slot_free   = !r_valid || arb.data_out_ready;
  assign w_grant       = (r_state == StLocked) ? r_lock_id : w_rr_grant;
  assign w_grant_valid = (r_state == StLocked) ? 1'b1 : w_rr_valid;

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    w_ready    = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (w_grant == ID_WIDTH'(i)) begin
        w_sel_data = arb.data_in[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_last = arb.data_in_last[i];
        w_ready[i] = w_slot_free && w_grant_valid;
      end
    end
  end

  assign w_xfer = |(w_ready & arb.data_in_valid);
  // Without packet locking every beat closes its grant.
  assign w_end  = LOCK_ON_LAST ? w_sel_last : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_ptr     <= ID_WIDTH'(NUM_IN - 1);
      r_lock_id <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_id      <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (w_slot_free) begin
        r_valid <= w_xfer;
        if (w_xfer) begin
          r_data <= w_sel_data;
          r_last <= w_sel_last;
          r_id   <= w_grant;
        end
      end
      if (w_xfer) begin
        if (w_end) begin
          r_ptr <= w_grant;
        end
        if (LOCK_ON_LAST) begin
          unique case (r_state)
            StIdle: begin
              if (!w_sel_last) begin
                r_state   <= StLocked;
                r_lock_id <= w_grant;
              end
            end
            StLocked: begin
              if (w_sel_last) begin
                r_state <= StIdle;
              end
            end
          endcase
        end
      end
    end
  end

  assign arb.data_in_ready  = w_ready;
  assign arb.data_out       = r_data;
  assign arb.data_out_last  = r_last;
  assign arb.data_out_id    = r_id;
  assign arb.data_out_valid = r_valid;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench: a packet-locking arbiter and a per-beat arbiter, both with four inputs.
// Inputs change on the falling edge; registered outputs are checked there too.
module tb_stream_rr_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  stream_rr_arbiter_if #(.NUM_IN(4), .DATA_WIDTH(32)) if_a ();
  stream_rr_arbiter_if #(.NUM_IN(4), .DATA_WIDTH(32)) if_b ();

  stream_rr_arbiter #(
    .NUM_IN       (4),
    .DATA_WIDTH   (32),
    .LOCK_ON_LAST (1'b1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .arb (if_a)
  );

  stream_rr_arbiter #(
    .NUM_IN       (4),
    .DATA_WIDTH   (32),
    .LOCK_ON_LAST (1'b0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .arb (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic out_a(input string tag, input logic v, input logic [1:0] id,
                       input logic [31:0] d, input logic l);
    chk({tag, ".valid"}, 64'(if_a.data_out_valid), 64'(v));
    chk({tag, ".id"},    64'(if_a.data_out_id),    64'(id));
    chk({tag, ".data"},  64'(if_a.data_out),       64'(d));
    chk({tag, ".last"},  64'(if_a.data_out_last),  64'(l));
  endtask

  task automatic out_b(input string tag, input logic v, input logic [1:0] id,
                       input logic [31:0] d, input logic l);
    chk({tag, ".valid"}, 64'(if_b.data_out_valid), 64'(v));
    chk({tag, ".id"},    64'(if_b.data_out_id),    64'(id));
    chk({tag, ".data"},  64'(if_b.data_out),       64'(d));
    chk({tag, ".last"},  64'(if_b.data_out_last),  64'(l));
  endtask

  task automatic edge_a();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    if_a.data_in        = '0;
    if_a.data_in_last   = '0;
    if_a.data_in_valid  = '0;
    if_a.data_out_ready = 1'b1;
    if_b.data_in        = '0;
    if_b.data_in_last   = '0;
    if_b.data_in_valid  = '0;
    if_b.data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) if_a.data_in[i*32 +: 32] = 32'h100 + 32'(i);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_a("rst_a", 1'b0, 2'd0, 32'h0, 1'b0);
    out_b("rst_b", 1'b0, 2'd0, 32'h0, 1'b0);
    #1;
    chk("rst_a.ready", 64'(if_a.data_in_ready), 64'h0);
    chk("rst_b.ready", 64'(if_b.data_in_ready), 64'h0);

    // Fairness: all valid, single-beat packets
    if_a.data_in_valid = 4'b1111;
    if_a.data_in_last  = 4'b1111;
    #1;
    chk("fair.ready0", 64'(if_a.data_in_ready), 64'b0001);
    for (int b = 0; b < 6; b++) begin
      edge_a();
      out_a($sformatf("fair%0d", b), 1'b1, 2'(b % 4), 32'h100 + 32'(b % 4), 1'b1);
    end

    // Lock: input 2 sends three beats while 0 and 1 wait
    if_a.data_in_valid = 4'b0111;
    if_a.data_in_last  = 4'b0011;
    if_a.data_in[2*32 +: 32] = 32'h200;
    #1;
    chk("lock.ready1", 64'(if_a.data_in_ready), 64'b0100);
    edge_a();
    out_a("lock.b1", 1'b1, 2'd2, 32'h200, 1'b0);
    if_a.data_in[2*32 +: 32] = 32'h201;
    #1;
    chk("lock.ready2", 64'(if_a.data_in_ready), 64'b0100);
    edge_a();
    out_a("lock.b2", 1'b1, 2'd2, 32'h201, 1'b0);
    if_a.data_in[2*32 +: 32] = 32'h202;
    if_a.data_in_last = 4'b0111;
    #1;
    chk("lock.ready3", 64'(if_a.data_in_ready), 64'b0100);
    edge_a();
    out_a("lock.b3", 1'b1, 2'd2, 32'h202, 1'b1);
    if_a.data_in_valid = 4'b0011;
    if_a.data_in[2*32 +: 32] = 32'h102;
    #1;
    chk("lock.ready_after", 64'(if_a.data_in_ready), 64'b0001);
    edge_a();
    out_a("lock.next0", 1'b1, 2'd0, 32'h100, 1'b1);
    edge_a();
    out_a("lock.next1", 1'b1, 2'd1, 32'h101, 1'b1);

    // Mid-packet bubble on locked input 1
    if_a.data_in_valid = 4'b0010;
    if_a.data_in_last  = 4'b1101;
    if_a.data_in[1*32 +: 32] = 32'h300;
    #1;
    chk("bub.ready1", 64'(if_a.data_in_ready), 64'b0010);
    edge_a();
    out_a("bub.b1", 1'b1, 2'd1, 32'h300, 1'b0);
    if_a.data_in_valid = 4'b1101;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("bub.others%0d", c), 64'(if_a.data_in_ready & 4'b1101), 64'h0);
      edge_a();
      chk($sformatf("bub.gap%0d", c), 64'(if_a.data_out_valid), 64'h0);
    end
    if_a.data_in_valid = 4'b1111;
    if_a.data_in_last  = 4'b1111;
    if_a.data_in[1*32 +: 32] = 32'h301;
    #1;
    chk("bub.ready2", 64'(if_a.data_in_ready), 64'b0010);
    edge_a();
    out_a("bub.b2", 1'b1, 2'd1, 32'h301, 1'b1);

    // Backpressure with the slot full
    if_a.data_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp.ready%0d", c), 64'(if_a.data_in_ready), 64'h0);
      edge_a();
      out_a($sformatf("bp.hold%0d", c), 1'b1, 2'd1, 32'h301, 1'b1);
    end
    if_a.data_out_ready = 1'b1;
    #1;
    chk("bp.release", 64'(if_a.data_in_ready), 64'b0100);
    edge_a();
    out_a("bp.next2", 1'b1, 2'd2, 32'h102, 1'b1);
    edge_a();
    out_a("bp.next3", 1'b1, 2'd3, 32'h103, 1'b1);

    // Reset while locked on input 1
    if_a.data_in_valid = 4'b0010;
    if_a.data_in_last  = 4'b0000;
    if_a.data_in[1*32 +: 32] = 32'h400;
    #1;
    chk("rstm.ready", 64'(if_a.data_in_ready), 64'b0010);
    edge_a();
    out_a("rstm.b1", 1'b1, 2'd1, 32'h400, 1'b0);
    rst = 1'b1;
    if_a.data_in_valid = 4'b1111;
    if_a.data_in_last  = 4'b1111;
    edge_a();
    out_a("rstm.cleared", 1'b0, 2'd0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rstm.idle_ready", 64'(if_a.data_in_ready), 64'b0001);
    edge_a();
    out_a("rstm.first", 1'b1, 2'd0, 32'h100, 1'b1);

    // Per-beat arbitration: inputs 0 and 3 with long packets
    if_b.data_in_valid = 4'b1001;
    if_b.data_in_last  = 4'b0000;
    if_b.data_in[0*32 +: 32] = 32'h500;
    if_b.data_in[3*32 +: 32] = 32'h503;
    #1;
    chk("nolock.ready0", 64'(if_b.data_in_ready), 64'b0001);
    for (int b = 0; b < 4; b++) begin
      edge_a();
      if (b % 2 == 0) out_b($sformatf("nolock%0d", b), 1'b1, 2'd0, 32'h500, 1'b0);
      else            out_b($sformatf("nolock%0d", b), 1'b1, 2'd3, 32'h503, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
